pmu_reset_ctrl: RTL and testbench

- Power-management and reset sequencer between the board pins and the core's `pmu_bus`.
- Debounces the reset/wake button and services software reset and shutdown requests from the core.
- Generates the core reset pulse and the core clock-enable, and records the cause of the last reset.
- Replaces the ad-hoc reset counter and shutdown flag logic currently written inline in each board top.

---
 rtl/pmu_reset_ctrl.sv | 137 +++++++++++++
 tb/tb_pmu_reset_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_reset_ctrl.sv
// Power-management and reset sequencer: button debounce, core reset pulse,
// core clock-enable and last-reset-cause bookkeeping.
module pmu_reset_ctrl #(
    parameter int RST_LEN         = 3,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter bit WAKE_ON_BTN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       req_rst,
    input  logic       req_shdn,
    output logic       core_rst,
    output logic       core_clk_en,
    output logic [1:0] rst_cause,
    output logic       btn_db,
    output logic [1:0] dbg_state
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(RST_LEN + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RST_LEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_WAKE = 2'd3;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_SHDN  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    cause_n;
    logic [1:0]    sync_q;
    logic [DW-1:0] db_cnt;
    logic          btn_db_q;
    logic          btn_s;
    logic          press;

    assign btn_s     = sync_q[1];
    assign press     = btn_db & ~btn_db_q;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_raw};
            btn_db_q <= btn_db;
            // btn_db only follows btn_s after DEBOUNCE_CYCLES consecutive disagreeing samples
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= ~btn_db;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RESET;
            cnt         <= CNT_LOAD;
            core_rst    <= 1'b1;
            core_clk_en <= 1'b1;
            rst_cause   <= CAUSE_POR;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rst_cause   <= cause_n;
            // outputs are decoded from the next state so they change with the transition
            core_rst    <= (state_n == ST_RESET);
            core_clk_en <= (state_n != ST_SHDN);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cause_n = rst_cause;
        case (state)
            ST_RESET: begin
                if (press) begin
                    cnt_n   = CNT_LOAD;
                    cause_n = CAUSE_BTN;
                end else if (req_rst) begin
                    cnt_n   = CNT_LOAD;
                    cause_n = CAUSE_SW;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (press) begin
                    state_n = ST_RESET;
                    cnt_n   = CNT_LOAD;
                    cause_n = CAUSE_BTN;
                end else if (req_rst) begin
                    state_n = ST_RESET;
                    cnt_n   = CNT_LOAD;
                    cause_n = CAUSE_SW;
                end else if (req_shdn) begin
                    state_n = ST_SHDN;
                end
            end
            ST_SHDN: begin
                // the request register sits outside the gated core, so req_rst still wakes us
                if (req_rst) begin
                    state_n = ST_RESET;
                    cnt_n   = CNT_LOAD;
                    cause_n = CAUSE_SW;
                end else if (WAKE_ON_BTN && press) begin
                    state_n = ST_RESET;
                    cnt_n   = CNT_LOAD;
                    cause_n = CAUSE_WAKE;
                end
            end
            default: begin
                state_n = ST_RESET;
                cnt_n   = CNT_LOAD;
            end
        endcase
    end
endmodule

// File: tb/tb_pmu_reset_ctrl.sv
// Directed bench for pmu_reset_ctrl: RST_LEN=3, DEBOUNCE_CYCLES=16, one
// instance with button wake and one without, driven from shared inputs.
module tb_pmu_reset_ctrl;
    logic       clk;
    logic       rst_n;
    logic       btn_raw;
    logic       req_rst;
    logic       req_shdn;
    logic       core_rst,    nw_core_rst;
    logic       core_clk_en, nw_core_clk_en;
    logic [1:0] rst_cause,   nw_rst_cause;
    logic       btn_db,      nw_btn_db;
    logic [1:0] dbg_state,   nw_dbg_state;

    int vectors;
    int miscompares;
    int n;

    pmu_reset_ctrl #(.RST_LEN(3), .DEBOUNCE_CYCLES(16), .WAKE_ON_BTN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .req_rst(req_rst), .req_shdn(req_shdn),
        .core_rst(core_rst), .core_clk_en(core_clk_en), .rst_cause(rst_cause),
        .btn_db(btn_db), .dbg_state(dbg_state)
    );

    pmu_reset_ctrl #(.RST_LEN(3), .DEBOUNCE_CYCLES(16), .WAKE_ON_BTN(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .req_rst(req_rst), .req_shdn(req_shdn),
        .core_rst(nw_core_rst), .core_clk_en(nw_core_clk_en), .rst_cause(nw_rst_cause),
        .btn_db(nw_btn_db), .dbg_state(nw_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_db(input logic lvl, input int max, output int cnt);
        cnt = 0;
        while (btn_db !== lvl && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (core_rst !== 1'b1 || core_clk_en !== 1'b1 || rst_cause !== 2'd0 || btn_db !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: rst=%b clk_en=%b cause=%0d db=%b, need 1 1 0 0",
                     core_rst, core_clk_en, rst_cause, btn_db);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (core_rst !== (i < 2) || core_clk_en !== 1'b1 || rst_cause !== 2'd0) begin
                miscompares++;
                $display("FAIL por_pulse[%0d]: rst=%b clk_en=%b cause=%0d, need %b 1 0",
                         i, core_rst, core_clk_en, rst_cause, (i < 2));
            end
        end
        vectors++;
        if (dbg_state !== 2'd1) begin
            miscompares++;
            $display("FAIL por_run_state: state=%0d need 1", dbg_state);
        end
    endtask

    task automatic test_glitch();
        btn_raw = 1'b1;
        repeat (5) tick();
        btn_raw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            vectors++;
            if (btn_db !== 1'b0 || core_rst !== 1'b0 || rst_cause !== 2'd0) begin
                miscompares++;
                $display("FAIL glitch[%0d]: db=%b rst=%b cause=%0d, need 0 0 0",
                         i, btn_db, core_rst, rst_cause);
            end
        end
    endtask

    task automatic test_btn_reset();
        btn_raw = 1'b1;
        wait_db(1'b1, 40, n);
        vectors++;
        if (n !== 18) begin
            miscompares++;
            $display("FAIL btn_db_rise: cycles=%0d need 18", n);
        end
        vectors++;
        if (core_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL btn_rst_not_yet: rst=%b need 0", core_rst);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (core_rst !== (i < 3) || rst_cause !== 2'd1) begin
                miscompares++;
                $display("FAIL btn_pulse[%0d]: rst=%b cause=%0d, need %b 1",
                         i, core_rst, rst_cause, (i < 3));
            end
        end
        repeat (8) tick();
        btn_raw = 1'b0;
        wait_db(1'b0, 40, n);
        vectors++;
        if (n !== 18) begin
            miscompares++;
            $display("FAIL btn_db_fall: cycles=%0d need 18", n);
        end
        repeat (5) tick();
        vectors++;
        if (core_rst !== 1'b0 || rst_cause !== 2'd1 || dbg_state !== 2'd1) begin
            miscompares++;
            $display("FAIL btn_release: rst=%b cause=%0d state=%0d, need 0 1 1",
                     core_rst, rst_cause, dbg_state);
        end
    endtask

    task automatic test_shdn_swrst();
        req_shdn = 1'b1;
        tick();
        req_shdn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (core_clk_en !== 1'b0 || core_rst !== 1'b0 || nw_core_clk_en !== 1'b0) begin
                miscompares++;
                $display("FAIL shdn[%0d]: clk_en=%b rst=%b nw_clk_en=%b, need 0 0 0",
                         i, core_clk_en, core_rst, nw_core_clk_en);
            end
            tick();
        end
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (core_rst !== (i < 3) || core_clk_en !== 1'b1 || rst_cause !== 2'd2) begin
                miscompares++;
                $display("FAIL sw_rst[%0d]: rst=%b clk_en=%b cause=%0d, need %b 1 2",
                         i, core_rst, core_clk_en, rst_cause, (i < 3));
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        btn_raw = 1'b1;
        wait_db(1'b1, 40, n);
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        vectors++;
        if (rst_cause !== 2'd1 || core_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_press_rst: cause=%0d rst=%b, need 1 1", rst_cause, core_rst);
        end
        btn_raw = 1'b0;
        wait_db(1'b0, 40, n);
        repeat (3) tick();
    endtask

    task automatic test_reload();
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        tick();
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (core_rst !== (i < 3) || rst_cause !== 2'd2) begin
                miscompares++;
                $display("FAIL reload[%0d]: rst=%b cause=%0d, need %b 2",
                         i, core_rst, rst_cause, (i < 3));
            end
            tick();
        end
    endtask

    task automatic test_rst_mid();
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (core_rst !== (i < 3) || rst_cause !== 2'd0 || core_clk_en !== 1'b1) begin
                miscompares++;
                $display("FAIL rst_mid[%0d]: rst=%b cause=%0d clk_en=%b, need %b 0 1",
                         i, core_rst, rst_cause, core_clk_en, (i < 3));
            end
            tick();
        end
    endtask

    task automatic test_wake();
        req_shdn = 1'b1;
        tick();
        req_shdn = 1'b0;
        btn_raw = 1'b1;
        wait_db(1'b1, 40, n);
        vectors++;
        if (n !== 18 || core_clk_en !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_pre: cycles=%0d clk_en=%b, need 18 0", n, core_clk_en);
        end
        tick();
        vectors++;
        if (core_clk_en !== 1'b1 || core_rst !== 1'b1 || rst_cause !== 2'd3) begin
            miscompares++;
            $display("FAIL wake_btn: clk_en=%b rst=%b cause=%0d, need 1 1 3",
                     core_clk_en, core_rst, rst_cause);
        end
        vectors++;
        if (nw_core_clk_en !== 1'b0 || nw_core_rst !== 1'b0 || nw_dbg_state !== 2'd2) begin
            miscompares++;
            $display("FAIL nowake_btn: clk_en=%b rst=%b state=%0d, need 0 0 2",
                     nw_core_clk_en, nw_core_rst, nw_dbg_state);
        end
        btn_raw = 1'b0;
        wait_db(1'b0, 40, n);
        vectors++;
        if (nw_core_clk_en !== 1'b0 || core_clk_en !== 1'b1 || core_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_after: nw_clk_en=%b clk_en=%b rst=%b, need 0 1 0",
                     nw_core_clk_en, core_clk_en, core_rst);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        btn_raw     = 1'b0;
        req_rst     = 1'b0;
        req_shdn    = 1'b0;
        test_reset();
        test_glitch();
        test_btn_reset();
        test_shdn_swrst();
        test_simultaneous();
        test_reload();
        test_rst_mid();
        test_wake();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
